mul_arb2: RTL and testbench

MUL_ARB2 -- requirements
Module: mul_arb2

---
 rtl/mul_arb2.sv | 91 +++++++++
 tb/tb_mul_arb2.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mul_arb2.sv
// Two-requester round-robin arbiter in front of one shared signed x unsigned
// multiplier; two-stage pipeline with a per-requester result strobe.
module mul_arb2 #(
  parameter int W = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_req0,
  input  logic [W-1:0]   i_a0,
  input  logic [W-1:0]   i_b0,
  input  logic           i_req1,
  input  logic [W-1:0]   i_a1,
  input  logic [W-1:0]   i_b1,
  output logic           o_gnt0,
  output logic           o_gnt1,
  output logic           o_vld0,
  output logic           o_vld1,
  output logic [2*W-1:0] o_y
);

  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } last_t;

  last_t              last_q;
  logic               s1_vld;
  logic               s1_tag;
  logic [W-1:0]       s1_a;
  logic [W-1:0]       s1_b;
  logic [2*W-1:0]     a_ext;
  logic [2*W-1:0]     b_ext;
  logic [2*W-1:0]     prod;
  logic               any_gnt;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the if/else leaves it unassigned and infers a latch.
  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (!i_rst) begin
      if (i_req0 && (!i_req1 || last_q == LAST1)) begin
        o_gnt0 = 1'b1;
      end else if (i_req1) begin
        o_gnt1 = 1'b1;
      end
    end
  end

  assign any_gnt = o_gnt0 | o_gnt1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_q <= LAST1;
      s1_vld <= 1'b0;
      o_vld0 <= 1'b0;
      o_vld1 <= 1'b0;
      o_y    <= '0;
    end else begin
      if (o_gnt0) begin
        last_q <= LAST0;
      end else if (o_gnt1) begin
        last_q <= LAST1;
      end
      s1_vld <= any_gnt;
      o_vld0 <= s1_vld && !s1_tag;
      o_vld1 <= s1_vld && s1_tag;
      if (s1_vld) begin
        o_y <= prod;
      end
    end
  end

  // NOTE: operand/tag registers carry no reset; s1_vld qualifies them, so
  // their contents after reset are never observed.
  always_ff @(posedge i_clk) begin
    if (any_gnt) begin
      s1_a   <= o_gnt1 ? i_a1 : i_a0;
      s1_b   <= o_gnt1 ? i_b1 : i_b0;
      s1_tag <= o_gnt1;
    end
  end

  // A sign-extended, B zero-extended; the 2W-bit product is exact for this mix.
  assign a_ext = {{W{s1_a[W-1]}}, s1_a};
  assign b_ext = {{W{1'b0}}, s1_b};
  assign prod  = a_ext * b_ext;

endmodule

// File: tb/tb_mul_arb2.sv
// Self-checking bench for mul_arb2: table-driven grant vectors plus a
// scoreboard of expected (tag, product, due cycle) results.
module tb_mul_arb2;

  localparam int W = 8;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic           i_req0, i_req1;
  logic [W-1:0]   i_a0, i_b0, i_a1, i_b1;
  logic           o_gnt0, o_gnt1, o_vld0, o_vld1;
  logic [2*W-1:0] o_y;

  mul_arb2 #(.W(W)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_req0(i_req0),
    .i_a0  (i_a0),
    .i_b0  (i_b0),
    .i_req1(i_req1),
    .i_a1  (i_a1),
    .i_b1  (i_b1),
    .o_gnt0(o_gnt0),
    .o_gnt1(o_gnt1),
    .o_vld0(o_vld0),
    .o_vld1(o_vld1),
    .o_y   (o_y)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit         rst;
    bit         r0;
    logic [7:0] a0;
    logic [7:0] b0;
    bit         r1;
    logic [7:0] a1;
    logic [7:0] b1;
    bit         g0;
    bit         g1;
  } vec_t;

  typedef struct {
    bit          tag;
    logic [15:0] y;
    int          due;
  } sb_t;

  vec_t        tbl[$];
  sb_t         sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          prev_rst = 1'b0;
  bit          y_known = 1'b0;
  logic [15:0] exp_y = '0;

  function automatic vec_t mk(bit rst, bit r0, logic [7:0] a0, logic [7:0] b0,
                              bit r1, logic [7:0] a1, logic [7:0] b1,
                              bit g0, bit g1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.a0 = a0; v.b0 = b0;
    v.r1 = r1;   v.a1 = a1; v.b1 = b1; v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  // Reference product in plain integer arithmetic.
  function automatic logic [15:0] ref_mul(logic [7:0] a, logic [7:0] b);
    int av, bv, p;
    av = int'($signed(a));
    bv = int'(b);
    p  = av * bv;
    return p[15:0];
  endfunction

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive, then sample on the falling edge.
  task automatic apply(input vec_t v);
    sb_t e;
    @(posedge i_clk);
    #1;
    i_rst = v.rst;
    i_req0 = v.r0; i_a0 = v.a0; i_b0 = v.b0;
    i_req1 = v.r1; i_a1 = v.a1; i_b1 = v.b1;
    @(negedge i_clk);

    if (v.rst) begin
      if (prev_rst) begin
        check(!o_vld0 && !o_vld1, "vld_in_reset", {o_vld1, o_vld0}, 0);
        check(o_y == 16'h0, "y_in_reset", o_y, 0);
      end
      sb.delete();
      exp_y   = '0;
      y_known = 1'b1;
    end else if (o_vld0 || o_vld1) begin
      if (sb.size() == 0) begin
        check(1'b0, "unexpected_vld", {o_vld1, o_vld0}, 0);
      end else begin
        e = sb.pop_front();
        check(e.due == cyc, "vld_latency", cyc, e.due);
        check(o_vld0 == !e.tag && o_vld1 == e.tag, "vld_tag",
              {o_vld1, o_vld0}, e.tag ? 2 : 1);
        check(o_y == e.y, "result_y", o_y, e.y);
        exp_y = e.y;
      end
    end else begin
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check(1'b0, "missing_vld", 0, e.tag ? 2 : 1);
      end
      if (y_known) check(o_y == exp_y, "y_hold", o_y, exp_y);
    end

    check(o_gnt0 == v.g0, "gnt0", o_gnt0, v.g0);
    check(o_gnt1 == v.g1, "gnt1", o_gnt1, v.g1);
    check(!(o_gnt0 && o_gnt1), "gnt_onehot", {o_gnt1, o_gnt0}, 0);

    if (v.g0) begin
      e.tag = 1'b0; e.y = ref_mul(v.a0, v.b0); e.due = cyc + 2;
      sb.push_back(e);
    end
    if (v.g1) begin
      e.tag = 1'b1; e.y = ref_mul(v.a1, v.b1); e.due = cyc + 2;
      sb.push_back(e);
    end
    prev_rst = v.rst;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1;
    i_req0 = 1'b0; i_a0 = '0; i_b0 = '0;
    i_req1 = 1'b0; i_a1 = '0; i_b1 = '0;

    // rst r0 a0 b0 r1 a1 b1 g0 g1
    tbl.push_back(mk(1, 1, 8'h11, 8'h22, 1, 8'h33, 8'h44, 0, 0));
    tbl.push_back(mk(1, 1, 8'h11, 8'h22, 1, 8'h33, 8'h44, 0, 0));
    tbl.push_back(mk(0, 1, 8'h80, 8'hFF, 0, 8'h00, 8'h00, 1, 0)); // -128*255
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(1, 1, 8'h03, 8'h04, 1, 8'h7F, 8'hFF, 0, 0));
    tbl.push_back(mk(1, 1, 8'h03, 8'h04, 1, 8'h7F, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 1, 8'h03, 8'h04, 1, 8'h7F, 8'hFF, 1, 0)); // contention x4
    tbl.push_back(mk(0, 1, 8'h03, 8'h04, 1, 8'h7F, 8'hFF, 0, 1));
    tbl.push_back(mk(0, 1, 8'h03, 8'h04, 1, 8'h7F, 8'hFF, 1, 0));
    tbl.push_back(mk(0, 1, 8'h03, 8'h04, 1, 8'h7F, 8'hFF, 0, 1));
    tbl.push_back(mk(0, 1, 8'hFF, 8'h01, 0, 8'h00, 8'h00, 1, 0)); // back-to-back
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 8'hFD, 8'hC8, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 1, 0)); // zero product
    tbl.push_back(mk(0, 1, 8'h09, 8'h02, 1, 8'h06, 8'h06, 0, 1)); // req0 loses...
    tbl.push_back(mk(0, 0, 8'h09, 8'h02, 0, 8'h00, 8'h00, 0, 0)); // ...and drops
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Operand change after the grant cycle must not reach the issued op.
    apply(mk(0, 1, 8'h05, 8'h03, 0, 8'h00, 8'h00, 1, 0));
    apply(mk(0, 0, 8'h07, 8'h03, 0, 8'h00, 8'h00, 0, 0));
    apply(mk(0, 0, 8'h07, 8'h03, 0, 8'h00, 8'h00, 0, 0));
    apply(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0));

    // Reset one cycle after a grant discards the op; pointer restarts at 1.
    apply(mk(0, 1, 8'h02, 8'h02, 0, 8'h00, 8'h00, 1, 0));
    apply(mk(1, 0, 8'h00, 8'h00, 1, 8'h01, 8'h01, 0, 0));
    apply(mk(0, 1, 8'h02, 8'h05, 1, 8'h01, 8'h01, 1, 0));
    check(o_y == 16'h0, "y_after_rst", o_y, 0);
    apply(mk(0, 0, 8'h00, 8'h00, 1, 8'h81, 8'h02, 0, 1));
    for (int i = 0; i < 4; i++) apply(mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0));

    check(sb.size() == 0, "sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
